// File: rtl/kbd_scan_fifo.sv
// Matrix keypad scanner: rotating column strobe, per-frame key classification,
// frame-based debounce with multi-key rejection, and a key-event FIFO.
//
// state   | meaning
// S_IDLE  | no key accepted; waiting for a single-key frame
// S_PRESS | candidate key latched; counting identical single-key frames
// S_HELD  | key accepted and pushed; waiting for an empty frame
// S_REL   | counting empty frames before re-arming
module kbd_scan_fifo #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DEBOUNCE = 3,
   parameter int FIFO_DEPTH = 4,
   localparam int CODE_W = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ROWS-1:0]   fila,
   output logic [COLS-1:0]   col,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ack,
   input  logic              ovf_clr,
   output logic              overflow
);

   localparam int CIDX_W = $clog2(COLS);
   localparam int RIDX_W = $clog2(ROWS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam int CNT_W  = $clog2(DEBOUNCE + 1);
   localparam logic [CIDX_W-1:0] LAST_COL = CIDX_W'(COLS - 1);
   localparam logic [CNT_W-1:0]  DEB_LOAD = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_t;

   state_t             state;
   logic [CNT_W-1:0]   frames_left;
   logic [CODE_W-1:0]  cur_code;
   logic [CIDX_W-1:0]  col_idx;
   logic               frame_end;
   logic [1:0]         cyc_hits;
   logic [RIDX_W-1:0]  cyc_row;
   logic [CODE_W-1:0]  cyc_code;
   logic [1:0]         acc_hits;
   logic [CODE_W-1:0]  acc_code;
   logic [2:0]         sum_hits;
   logic               frm_none;
   logic               frm_single;
   logic [CODE_W-1:0]  frm_code;
   logic               push;

   logic [CODE_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FCNT_W-1:0]  count;
   logic               pop;
   logic               full;
   logic               drop;
   logic               do_push;

   assign frame_end = (col_idx == LAST_COL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col     <= COLS'(1);
         col_idx <= '0;
      end else begin
         col     <= {col[COLS-2:0], col[COLS-1]};
         col_idx <= frame_end ? '0 : col_idx + CIDX_W'(1);
      end
   end

   // Hit count saturates at 2: anything beyond one key is simply "multi".
   always_comb begin
      cyc_hits = '0;
      cyc_row  = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (fila[r]) begin
            cyc_row = RIDX_W'(r);
            if (cyc_hits != 2'd2) cyc_hits = cyc_hits + 2'd1;
         end
      end
   end

   assign cyc_code   = CODE_W'(int'(cyc_row) * COLS + int'(col_idx));
   assign sum_hits   = {1'b0, acc_hits} + {1'b0, cyc_hits};
   assign frm_none   = (sum_hits == 3'd0);
   assign frm_single = (sum_hits == 3'd1);
   assign frm_code   = (cyc_hits != 2'd0) ? cyc_code : acc_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hits <= '0;
         acc_code <= '0;
      end else if (frame_end) begin
         acc_hits <= '0;
         acc_code <= '0;
      end else begin
         acc_hits <= (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
         if (cyc_hits != 2'd0) acc_code <= cyc_code;
      end
   end

   always_comb begin
      push = 1'b0;
      if (frame_end && frm_single) begin
         case (state)
            S_IDLE:  push = (DEBOUNCE == 1);
            S_PRESS: push = (frm_code == cur_code) && (frames_left == CNT_ONE);
            default: push = 1'b0;
         endcase
      end
   end

   // frames_left counts down the frames still needed to confirm a press or release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         frames_left <= '0;
         cur_code    <= '0;
      end else if (frame_end) begin
         case (state)
            S_IDLE: begin
               if (frm_single) begin
                  cur_code    <= frm_code;
                  frames_left <= DEB_LOAD;
                  state       <= push ? S_HELD : S_PRESS;
               end
            end
            S_PRESS: begin
               if (!frm_single) begin
                  state <= S_IDLE;
               end else if (frm_code != cur_code) begin
                  cur_code    <= frm_code;
                  frames_left <= DEB_LOAD;
               end else if (push) begin
                  state <= S_HELD;
               end else begin
                  frames_left <= frames_left - CNT_ONE;
               end
            end
            S_HELD: begin
               if (frm_none) begin
                  if (DEBOUNCE == 1) begin
                     state <= S_IDLE;
                  end else begin
                     frames_left <= DEB_LOAD;
                     state       <= S_REL;
                  end
               end
            end
            default: begin
               if (!frm_none) begin
                  state <= S_HELD;
               end else if (frames_left == CNT_ONE) begin
                  state <= S_IDLE;
               end else begin
                  frames_left <= frames_left - CNT_ONE;
               end
            end
         endcase
      end
   end

   assign key_valid = (count != '0);
   assign pop       = key_valid && key_ack;
   assign full      = (count == FULL_CNT);
   assign drop      = push && full && !pop;
   assign do_push   = push && !drop;
   assign key_code  = key_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= cur_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, pop})
            2'b10:   count <= count + FCNT_W'(1);
            2'b01:   count <= count - FCNT_W'(1);
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Bench for kbd_scan_fifo: directed scenarios plus randomized keypad activity,
// all compared against a cycle-level reference model of the keypad behaviour.
module tb_kbd_scan_fifo;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DEBOUNCE = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int CODE_W = $clog2(ROWS * COLS);
   localparam int M_IDLE = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ROWS-1:0]   fila;
   logic [COLS-1:0]   col;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ack = 1'b0;
   logic              ovf_clr = 1'b0;
   logic              overflow;

   logic [ROWS*COLS-1:0] keys = '0;
   int checks = 0;
   int errors = 0;

   int m_phase, m_acc, m_sc, m_st, m_cnt, m_lc;
   bit m_ovf;
   int m_q[$];

   always #5 clk = ~clk;

   kbd_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .fila(fila), .col(col), .key_code(key_code),
      .key_valid(key_valid), .key_ack(key_ack), .ovf_clr(ovf_clr), .overflow(overflow)
   );

   // Keypad: a row line is high when a pressed key sits on the strobed column.
   always_comb begin
      fila = '0;
      for (int r = 0; r < ROWS; r++) fila[r] = |(keys[r*COLS +: COLS] & col);
   end

   function automatic void model_reset();
      m_phase = 0; m_acc = 0; m_sc = 0; m_st = M_IDLE; m_cnt = 0; m_lc = 0;
      m_ovf = 1'b0;
      m_q.delete();
   endfunction

   function automatic void model_step();
      logic [CODE_W-1:0] kidx;
      int cls;
      bit do_push, do_pop, was_full, dropped;
      if (!rst_n) begin
         model_reset();
         return;
      end
      do_push = 1'b0;
      dropped = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         kidx = CODE_W'(r * COLS + m_phase);
         if (keys[kidx]) begin
            m_acc++;
            m_sc = r * COLS + m_phase;
         end
      end
      if (m_phase == COLS - 1) begin
         cls = (m_acc == 0) ? 0 : (m_acc == 1) ? 1 : 2;
         case (m_st)
            M_IDLE: if (cls == 1) begin
               m_lc = m_sc; m_cnt = 1;
               if (m_cnt == DEBOUNCE) begin do_push = 1'b1; m_st = M_HELD; end
               else m_st = M_PRESS;
            end
            M_PRESS: if (cls == 1 && m_sc == m_lc) begin
               m_cnt++;
               if (m_cnt == DEBOUNCE) begin do_push = 1'b1; m_st = M_HELD; end
            end else if (cls == 1) begin
               m_lc = m_sc; m_cnt = 1;
            end else m_st = M_IDLE;
            M_HELD: if (cls == 0) begin
               m_cnt = 1;
               m_st = (m_cnt == DEBOUNCE) ? M_IDLE : M_REL;
            end
            default: if (cls == 0) begin
               m_cnt++;
               if (m_cnt == DEBOUNCE) m_st = M_IDLE;
            end else m_st = M_HELD;
         endcase
         m_acc = 0;
         m_phase = 0;
      end else begin
         m_phase++;
      end
      was_full = (m_q.size() == FIFO_DEPTH);
      do_pop = key_ack && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         if (was_full && !do_pop) dropped = 1'b1;
         else m_q.push_back(m_lc);
      end
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_keys(input int a, input int b);
      logic [CODE_W-1:0] kidx;
      keys = '0;
      if (a >= 0) begin kidx = CODE_W'(a); keys[kidx] = 1'b1; end
      if (b >= 0) begin kidx = CODE_W'(b); keys[kidx] = 1'b1; end
   endtask

   task automatic align();
      int guard = 0;
      while (m_phase != 0 && guard < COLS) begin
         tick();
         guard++;
      end
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
   endtask

   task automatic press_release(input int code, input int hold_fr, input int rel_fr);
      align();
      set_keys(code, -1);
      ticks(hold_fr * COLS);
      set_keys(-1, -1);
      ticks(rel_fr * COLS);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      ticks(2);
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL reset_col: got %b expected 0001", col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
      checks++; if (key_code !== '0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_single_press();
      set_keys(6, -1);
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 11) begin
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0 at cycle 11", key_valid); end
         end
      end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1 at cycle 12", key_valid); end
      checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL single_code: got %0d expected 6", key_code); end
      ticks(28);
      set_keys(-1, -1);
      ticks(5 * COLS);
      checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL single_hold_code: got %0d expected 6", key_code); end
      ack_pulse();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_count: got valid %b expected 0 after one pop", key_valid); end
   endtask

   task automatic test_bounce();
      int pat [6] = '{1, 1, 0, 1, 1, 1};
      align();
      for (int f = 0; f < 6; f++) begin
         set_keys(pat[f] ? 0 : -1, -1);
         ticks(f == 5 ? COLS - 1 : COLS);
      end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b expected 0", key_valid); end
      tick();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_push: got %b expected 1", key_valid); end
      checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL bounce_code: got %0d expected 0", key_code); end
      set_keys(-1, -1); ticks(2 * COLS);
      set_keys(0, -1);  ticks(3 * COLS);
      set_keys(-1, -1); ticks(4 * COLS);
      ack_pulse();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_rel_repress: got valid %b expected 0", key_valid); end
   endtask

   task automatic test_multi();
      align();
      set_keys(1, 13);
      ticks(4 * COLS);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_reject: got %b expected 0", key_valid); end
      set_keys(1, -1);
      ticks(3 * COLS - 1);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_early: got %b expected 0", key_valid); end
      tick();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL multi_push: got %b expected 1", key_valid); end
      checks++; if (key_code !== 4'd1) begin errors++; $display("FAIL multi_code: got %0d expected 1", key_code); end
      set_keys(1, 5);   ticks(4 * COLS);
      set_keys(5, -1);  ticks(3 * COLS);
      set_keys(-1, -1); ticks(4 * COLS);
      ack_pulse();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_second_key: got valid %b expected 0", key_valid); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 4; k++) press_release(k, 3, 3);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_drop: got %b expected 0", overflow); end
      press_release(4, 3, 3);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
      align();
      set_keys(5, -1);
      ticks(3 * COLS - 1);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
      set_keys(-1, -1); ticks(3 * COLS);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %b expected 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (key_valid !== 1'b1 || key_code !== CODE_W'(i)) begin
            errors++; $display("FAIL ovf_pop_order: got valid %b code %0d expected valid 1 code %0d", key_valid, key_code, i);
         end
         ack_pulse();
      end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", key_valid); end
   endtask

   task automatic test_handshake();
      int exp4 [4] = '{9, 10, 11, 12};
      key_ack = 1'b1; tick(); key_ack = 1'b0;
      checks++; if (key_valid !== 1'b0 || key_code !== '0 || overflow !== 1'b0) begin
         errors++; $display("FAIL ack_empty: got valid %b code %0d ovf %b expected 0 0 0", key_valid, key_code, overflow);
      end
      for (int k = 8; k < 12; k++) press_release(k, 3, 3);
      align();
      set_keys(12, -1);
      ticks(3 * COLS - 1);
      key_ack = 1'b1; tick(); key_ack = 1'b0;
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin errors++; $display("FAIL full_pushpop_head: got valid %b code %0d expected 1 9", key_valid, key_code); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); end
      set_keys(-1, -1); ticks(3 * COLS);
      for (int i = 0; i < 4; i++) begin
         checks++; if (key_valid !== 1'b1 || key_code !== CODE_W'(exp4[i])) begin
            errors++; $display("FAIL full_pushpop_order: got valid %b code %0d expected 1 %0d", key_valid, key_code, exp4[i]);
         end
         ack_pulse();
      end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL full_pushpop_count: got %b expected 0", key_valid); end
      press_release(14, 3, 3);
      align();
      set_keys(15, -1);
      ticks(3 * COLS - 1);
      key_ack = 1'b1; tick(); key_ack = 1'b0;
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd15) begin errors++; $display("FAIL one_pushpop_head: got valid %b code %0d expected 1 15", key_valid, key_code); end
      set_keys(-1, -1); ticks(3 * COLS);
      ack_pulse();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL one_pushpop_count: got %b expected 0", key_valid); end
   endtask

   task automatic test_reset_mid();
      press_release(2, 3, 3);
      align();
      set_keys(7, -1);
      ticks(4 * COLS + 2);
      checks++; if (key_valid !== 1'b1 || m_q.size() != 2 || m_st != M_HELD) begin
         errors++; $display("FAIL rst_setup: got valid %b model entries %0d state %0d expected 1 2 %0d", key_valid, m_q.size(), m_st, M_HELD);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (col !== 4'b0001 || key_valid !== 1'b0 || key_code !== '0 || overflow !== 1'b0) begin
         errors++; $display("FAIL rst_mid: got col %b valid %b code %0d ovf %b expected 0001 0 0 0", col, key_valid, key_code, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 11) begin
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_held_early: got %b expected 0", key_valid); end
         end
      end
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd7) begin errors++; $display("FAIL rst_held_event: got valid %b code %0d expected 1 7", key_valid, key_code); end
      set_keys(-1, -1); ticks(4 * COLS);
      ack_pulse();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_held_count: got %b expected 0", key_valid); end
   endtask

   task automatic test_random();
      logic [COLS-1:0]   exp_col;
      logic [CODE_W-1:0] exp_code;
      int sel;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(0, 23) == 0) begin
            sel = $urandom_range(0, 19);
            if (sel < 10)      set_keys(-1, -1);
            else if (sel < 17) set_keys($urandom_range(0, ROWS*COLS-1), -1);
            else               set_keys($urandom_range(0, ROWS*COLS-1), $urandom_range(0, ROWS*COLS-1));
         end
         key_ack = ($urandom_range(0, 9) == 0);
         ovf_clr = ($urandom_range(0, 31) == 0);
         tick();
         for (int c = 0; c < COLS; c++) exp_col[c] = (c == m_phase);
         exp_code = (m_q.size() > 0) ? CODE_W'(m_q[0]) : '0;
         checks++; if (col !== exp_col) begin errors++; $display("FAIL rand_col: cycle %0d got %b expected %b", cyc, col, exp_col); end
         checks++; if (key_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %0d", cyc, key_valid, m_q.size() > 0); end
         checks++; if (key_code !== exp_code) begin errors++; $display("FAIL rand_code: cycle %0d got %0d expected %0d", cyc, key_code, exp_code); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf: cycle %0d got %b expected %b", cyc, overflow, m_ovf); end
      end
      key_ack = 1'b0;
      ovf_clr = 1'b0;
      set_keys(-1, -1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_overflow();
      test_handshake();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kbd_scan_fifo.md
# kbd_scan_fifo

Parametrised matrix-keypad scanner with per-key debounce, multi-key rejection and a key-event FIFO. It drives one-hot column strobes, samples the row inputs, and emits one key code per debounced press into a small FIFO. The consumer pops the FIFO with a valid/ack handshake. It sits between the keypad pins and the display/control logic, running on the slow scan clock.

## Interface
- `ROWS`, default 4: number of row inputs; must be ≥ 2.
- `COLS`, default 4: number of column outputs; must be ≥ 2.
- `DEBOUNCE`, default 3: number of consecutive identical scan frames required to accept a press or a release; must be ≥ 1.
- `FIFO_DEPTH`, default 4: key-event FIFO entries; must be a power of two, ≥ 2.
- `CODE_W` (localparam) = `$clog2(ROWS*COLS)`.

Ports (clock and reset first):
- `clk`  in  1: scan clock; the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `fila`  in  ROWS: row sense lines, active-high. They reflect the column currently driven, in the same cycle.
- `col`  out  COLS: one-hot column strobe, registered.
- `key_code`  out  CODE_W: FIFO head; code = row_index*COLS + col_index.
- `key_valid`  out  1: FIFO not empty.
- `key_ack`  in  1: pop the FIFO head when `key_valid` is 1.
- `ovf_clr`  in  1: synchronous clear of `overflow`.
- `overflow`  out  1: sticky flag; set when a press is dropped because the FIFO is full.

## Operation
- **Scan**
  - `col` rotates left one bit per clk: bit 0 → bit COLS-1 → bit 0.
  - A frame is COLS cycles, starting with `col` = bit 0.
- **Frame accumulation**
  - Each cycle, count the active `fila` bits.
  - The frame result is classified at the end of the bit COLS-1 cycle:
    - NONE: zero active bits in the whole frame.
    - SINGLE(code): exactly one active bit.
    - MULTI: two or more active bits.
  - The accumulator clears at the start of every frame.
- **Debounce FSM** (updates once per frame, at frame end; `cnt` counts frames):
  - IDLE:
    - SINGLE(c): latch c, set cnt=1, go to PRESS.
    - Otherwise: stay.
  - PRESS:
    - SINGLE(same c): cnt++. When cnt reaches DEBOUNCE, push c and go to HELD.
    - SINGLE(different c): relatch, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt=1, go to REL.
    - SINGLE or MULTI: stay. A second key or a key change while held never emits an event.
  - REL:
    - NONE: cnt++. When cnt reaches DEBOUNCE, go to IDLE.
    - SINGLE or MULTI: go back to HELD.
  - If DEBOUNCE=1, the push happens at the end of the first SINGLE frame, and REL exits to IDLE after one NONE frame.
  - One press yields exactly one push.
- **FIFO**
  - Circular buffer with pointers and a count of width `$clog2(FIFO_DEPTH)+1`.
  - Pop occurs when `key_valid && key_ack`.
  - `key_ack` while empty is ignored.
  - Push while full and not popping: the code is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both occur, no drop, count unchanged.
  - Push and pop in the same cycle while count=1: the new code becomes the head, count stays 1.
  - `key_code` is the head entry and is held stable while `key_valid`=1 and no pop occurs. When empty it is 0.
- **Overflow**
  - `ovf_clr` clears `overflow` unless a drop occurs in the same cycle; set wins.

## Timing
- **Reset** (async assert, sync deassert handled at top level):
  - `col`=1 (bit 0), `key_valid`=0, `key_code`=0, `overflow`=0.
  - FIFO empty, FSM IDLE, accumulator and cnt cleared.
- **First cycle after reset release:** `col`=bit 0 and frame 0 begins.
- **Press latency:** a key stable from the start of frame k is pushed on the clk edge ending frame k+DEBOUNCE-1. `key_valid` and `key_code` are valid immediately after that edge, i.e. COLS*DEBOUNCE cycles after frame k starts.
- **Pop:** takes effect on the edge where `key_ack`=1. The next head, or `key_valid`=0, is visible after that edge.
- **Reset mid-operation** (mid-frame, in PRESS/HELD, or with a non-empty FIFO): everything returns to reset values at once, and no event is generated for a key held across reset until it is debounced again from IDLE.
- No combinational path from `fila` or `key_ack` to any output.

## Test plan
All cases use ROWS=4, COLS=4, DEBOUNCE=3, FIFO_DEPTH=4.

1. **Single press:** hold row 1 / col 2 for 10 frames from reset, then release → exactly one event, `key_code`=6. `key_valid` rises 12 cycles after frame 0 starts.
2. **Bounce:** key (row 0, col 0) present 2 frames, absent 1, present 3 → one event, code 0, pushed at the end of the 6th frame. Absent 2 frames then present again while in REL → no second event.
3. **Multi-key:** rows 0 and 3 active in col 1 → no event. Release row 3 → event code 1 after 3 frames. Then press code 5 while code 1 is held → no event.
4. **Overflow:** 5 distinct debounced presses, no ack → codes pop in order 0, 1, 2, 3 and the 5th is dropped. `overflow`=1 until `ovf_clr`, then 0. `ovf_clr` in the same cycle as a drop leaves `overflow`=1.
5. **Handshake edges:**
   - `key_ack` while empty → no state change.
   - Push and ack in the same cycle while full → count stays 4 and `overflow` stays 0.
6. **Reset:** assert `rst_n` mid-frame while in HELD with 2 FIFO entries → `col`=0001, `key_valid`=0, FIFO empty. The key still held after reset produces one event after 3 frames.
